// File: rtl/mxv_frame_dispatcher.sv
// ---------------------------------------------------------------------------
// mxv_frame_dispatcher
//
// Purpose:
//   Parses framed commands arriving byte-by-byte from a UART receiver:
//       0xFE, LEN, CMD, payload[LEN-2], 0xEF
//   Each valid frame is dispatched to one of N_CMD command handlers with a
//   one-cycle start pulse, a stable copy of the payload and its byte count.
//   Malformed, timed-out or refused frames are discarded. Each discard
//   produces an error pulse, a cause code and a saturating discard count.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   UART_Rx      received byte, meaningful only while Flag_Rx=1
//   Flag_Rx      one-cycle strobe marking a new byte on UART_Rx
//   cmd_busy     bit k=1: handler for CMD k+1 cannot accept a start
//   cmd_start    one-hot, one-cycle start pulse (bit CMD-1)
//   cmd_payload  dispatched payload, byte i at [8i+7:8i], unused bytes 0
//   cmd_pay_len  payload byte count of the last dispatched frame
//   rx_busy      high while a frame is being received
//   frame_err    one-cycle pulse when a frame is discarded
//   err_code     last discard cause: 1 LEN, 2 CMD, 3 EOF, 4 BUSY, 5 TIMEOUT
//   err_count    number of discarded frames, saturating at 255
// ---------------------------------------------------------------------------
module mxv_frame_dispatcher #(
    parameter int N_CMD       = 4,
    parameter int MAX_PAY     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   UART_Rx,
    input  logic                         Flag_Rx,
    input  logic [N_CMD-1:0]             cmd_busy,
    output logic [N_CMD-1:0]             cmd_start,
    output logic [8*MAX_PAY-1:0]         cmd_payload,
    output logic [$clog2(MAX_PAY+1)-1:0] cmd_pay_len,
    output logic                         rx_busy,
    output logic                         frame_err,
    output logic [2:0]                   err_code,
    output logic [7:0]                   err_count
);

    localparam int IDX_W  = (MAX_PAY > 1) ? $clog2(MAX_PAY) : 1;
    localparam int CIDX_W = (N_CMD > 1) ? $clog2(N_CMD) : 1;
    localparam int PL_W   = $clog2(MAX_PAY + 1);
    localparam int TC_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]      BYTE_SOF = 8'hFE;
    localparam logic [7:0]      BYTE_EOF = 8'hEF;
    localparam logic [7:0]      LEN_MAX  = 8'(MAX_PAY + 2);
    localparam logic [7:0]      CODE_MAX = 8'(N_CMD);
    // Timeout fires on the TIMEOUT_CYC-th consecutive byte-less cycle.
    localparam logic [TC_W-1:0] TC_LAST  = TC_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ERR_LEN  = 3'd1;
    localparam logic [2:0] ERR_CMD  = 3'd2;
    localparam logic [2:0] ERR_EOF  = 3'd3;
    localparam logic [2:0] ERR_BUSY = 3'd4;
    localparam logic [2:0] ERR_TOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_CMD,
        S_PAY,
        S_EOF
    } state_t;

    state_t              r_state;
    logic [7:0]          r_len;
    logic [CIDX_W-1:0]   r_code_idx;     // CMD-1, used directly as handler index
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_buf [MAX_PAY];
    logic [TC_W-1:0]     r_tcnt;

    logic                w_len_ok;
    logic                w_cmd_ok;
    logic                w_pay_last;
    logic                w_timeout;
    logic                w_err;
    logic [2:0]          w_err_code;
    logic                w_dispatch;
    logic [7:0]          w_pay_cnt;
    logic [N_CMD-1:0]    w_onehot;
    logic [8*MAX_PAY-1:0] w_pay_masked;

    // LEN and CMD range checks are plain unsigned 8-bit compares.
    assign w_len_ok   = (UART_Rx >= 8'd2) && (UART_Rx <= LEN_MAX);
    assign w_cmd_ok   = (UART_Rx >= 8'd1) && (UART_Rx <= CODE_MAX);
    assign w_pay_cnt  = r_len - 8'd2;
    assign w_pay_last = (8'(r_idx) + 8'd1) == w_pay_cnt;
    assign w_timeout  = (r_state != S_IDLE) && !Flag_Rx && (r_tcnt == TC_LAST);
    assign w_onehot   = N_CMD'(1) << r_code_idx;
    assign rx_busy    = (r_state != S_IDLE);

    // Bytes beyond this frame's payload may hold stale data from an earlier,
    // longer frame; they are forced to zero on the way out.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_PAY; gi++) begin : g_pay
            assign w_pay_masked[8*gi +: 8] = (8'(gi) < w_pay_cnt) ? r_buf[gi] : 8'h00;
        end
    endgenerate

    // Frame-terminating events for this cycle: either a discard with its
    // cause, or a dispatch. At most one of the two is ever set.
    always_comb begin
        w_err      = 1'b0;
        w_err_code = 3'd0;
        w_dispatch = 1'b0;
        if (Flag_Rx) begin
            case (r_state)
                S_LEN: begin
                    if (!w_len_ok) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_LEN;
                    end
                end
                S_CMD: begin
                    if (!w_cmd_ok) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CMD;
                    end
                end
                S_EOF: begin
                    if (UART_Rx != BYTE_EOF) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_EOF;
                    end else if (cmd_busy[r_code_idx]) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_BUSY;
                    end else begin
                        w_dispatch = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (w_timeout) begin
            w_err      = 1'b1;
            w_err_code = ERR_TOUT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_len       <= 8'd0;
            r_code_idx  <= '0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            for (int i = 0; i < MAX_PAY; i++) begin
                r_buf[i] <= 8'h00;
            end
            cmd_start   <= '0;
            cmd_payload <= '0;
            cmd_pay_len <= '0;
            frame_err   <= 1'b0;
            err_code    <= 3'd0;
            err_count   <= 8'd0;
        end else begin
            cmd_start <= '0;
            frame_err <= 1'b0;

            // ---------------- frame parser ----------------
            if (Flag_Rx) begin
                // A byte always wins over a timeout landing on the same cycle.
                r_tcnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (UART_Rx == BYTE_SOF) begin
                            r_state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len   <= UART_Rx;
                            r_idx   <= '0;
                            r_state <= S_CMD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_CMD: begin
                        if (w_cmd_ok) begin
                            r_code_idx <= CIDX_W'(UART_Rx - 8'd1);
                            r_state    <= (r_len == 8'd2) ? S_EOF : S_PAY;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_PAY: begin
                        // The LEN check bounds r_idx to MAX_PAY-1 here.
                        r_buf[r_idx] <= UART_Rx;
                        r_idx        <= r_idx + 1'b1;
                        if (w_pay_last) begin
                            r_state <= S_EOF;
                        end
                    end
                    S_EOF: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (w_timeout) begin
                    r_state <= S_IDLE;
                    r_tcnt  <= '0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end

            // ---------------- registered results ----------------
            if (w_dispatch) begin
                cmd_start   <= w_onehot;
                cmd_payload <= w_pay_masked;
                cmd_pay_len <= PL_W'(w_pay_cnt);
            end

            if (w_err) begin
                frame_err <= 1'b1;
                err_code  <= w_err_code;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mxv_frame_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_mxv_frame_dispatcher
//
// Self-checking bench for mxv_frame_dispatcher. A frame-level reference
// model (byte queue of the frame being collected) predicts every output after
// each clock. A table of directed vectors carries hand-derived expectations.
// Hand-written sequences cover timeout, reset mid-frame and counter
// saturation. A randomized frame stream is checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_mxv_frame_dispatcher;

    localparam int N_CMD   = 4;
    localparam int MAX_PAY = 8;
    localparam int TO      = 40;
    localparam int PL_W    = $clog2(MAX_PAY + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [7:0]           UART_Rx = 8'h00;
    logic                 Flag_Rx = 1'b0;
    logic [N_CMD-1:0]     cmd_busy = '0;
    logic [N_CMD-1:0]     cmd_start;
    logic [8*MAX_PAY-1:0] cmd_payload;
    logic [PL_W-1:0]      cmd_pay_len;
    logic                 rx_busy;
    logic                 frame_err;
    logic [2:0]           err_code;
    logic [7:0]           err_count;

    mxv_frame_dispatcher #(
        .N_CMD      (N_CMD),
        .MAX_PAY    (MAX_PAY),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .UART_Rx    (UART_Rx),
        .Flag_Rx    (Flag_Rx),
        .cmd_busy   (cmd_busy),
        .cmd_start  (cmd_start),
        .cmd_payload(cmd_payload),
        .cmd_pay_len(cmd_pay_len),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  q[$];          // bytes of the frame collected so far
    int          idle;          // byte-less cycles since the last byte
    logic [3:0]  m_start;
    logic [63:0] m_pay;
    int          m_plen;
    logic        m_err;
    int          m_code;
    int          m_cnt;

    task automatic model_reset();
        q.delete();
        idle    = 0;
        m_start = '0;
        m_pay   = '0;
        m_plen  = 0;
        m_err   = 1'b0;
        m_code  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_discard(input int cause);
        m_err  = 1'b1;
        m_code = cause;
        if (m_cnt < 255) m_cnt++;
        q.delete();
        idle = 0;
    endtask

    task automatic model_step(input bit f, input logic [7:0] b, input logic [3:0] busy);
        int len;
        int code;
        m_start = '0;
        m_err   = 1'b0;
        if (f) begin
            idle = 0;
            if (q.size() == 0) begin
                if (b == 8'hFE) q.push_back(b);
            end else if (q.size() == 1) begin
                if (b >= 2 && b <= MAX_PAY + 2) q.push_back(b);
                else model_discard(1);
            end else if (q.size() == 2) begin
                if (b >= 1 && b <= N_CMD) q.push_back(b);
                else model_discard(2);
            end else begin
                len  = int'(q[1]);
                code = int'(q[2]);
                // A full frame is LEN+2 bytes; the last one must be 0xEF.
                if (q.size() < len + 1) begin
                    q.push_back(b);
                end else if (b != 8'hEF) begin
                    model_discard(3);
                end else if (busy[code-1]) begin
                    model_discard(4);
                end else begin
                    m_start = 4'(1 << (code - 1));
                    m_pay   = '0;
                    for (int i = 0; i < len - 2; i++) m_pay[8*i +: 8] = q[3+i];
                    m_plen  = len - 2;
                    q.delete();
                end
            end
        end else if (q.size() != 0) begin
            idle++;
            if (idle == TO) model_discard(5);
        end
    endtask

    task automatic compare_all();
        chk("cmd_start",   64'(cmd_start),   64'(m_start));
        chk("cmd_payload", cmd_payload,      m_pay);
        chk("cmd_pay_len", 64'(cmd_pay_len), 64'(m_plen));
        chk("frame_err",   64'(frame_err),   64'(m_err));
        chk("err_code",    64'(err_code),    64'(m_code));
        chk("err_count",   64'(err_count),   64'(m_cnt));
        chk("rx_busy",     64'(rx_busy),     64'(q.size() != 0));
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic cyc(input bit f, input logic [7:0] b, input logic [3:0] busy);
        Flag_Rx  = f;
        UART_Rx  = f ? b : 8'($urandom);   // bus content is junk without the strobe
        cmd_busy = busy;
        model_step(f, b, busy);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [3:0] rnd_busy();
        return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    endfunction

    task automatic rnd_byte(input logic [7:0] b);
        int g;
        g = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
        repeat (g) cyc(1'b0, 8'h00, rnd_busy());
        cyc(1'b1, b, rnd_busy());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         f;
        logic [7:0] b;
        logic [3:0] busy;
        logic [3:0] start;
        bit         err;
        logic [2:0] code;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit f, input logic [7:0] b, input logic [3:0] busy,
                       input logic [3:0] start, input bit err, input logic [2:0] code,
                       input logic [7:0] cnt);
        vec_t v;
        v.f = f; v.b = b; v.busy = busy; v.start = start;
        v.err = err; v.code = code; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        // FE 02 03 EF -> handler 3
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h03, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'hEF, 4'h0, 4'h4, 0, 3'd0, 8'd0);
        add(0, 8'h00, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        // FE 05 01 11 (gap) 22 33 EF -> handler 1, 3 payload bytes
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h05, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h01, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h11, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(0, 8'h00, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h22, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h33, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'hEF, 4'h0, 4'h1, 0, 3'd0, 8'd0);
        // FE 02 03 EF with handler 3 busy -> BUSY
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'h03, 4'h0, 4'h0, 0, 3'd0, 8'd0);
        add(1, 8'hEF, 4'h4, 4'h0, 1, 3'd4, 8'd1);
        // FE 0B -> LEN
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd4, 8'd1);
        add(1, 8'h0B, 4'h0, 4'h0, 1, 3'd1, 8'd2);
        // FE 02 07 -> CMD
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd1, 8'd2);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd1, 8'd2);
        add(1, 8'h07, 4'h0, 4'h0, 1, 3'd2, 8'd3);
        // FE 02 01 AA -> EOF
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd2, 8'd3);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd2, 8'd3);
        add(1, 8'h01, 4'h0, 4'h0, 0, 3'd2, 8'd3);
        add(1, 8'hAA, 4'h0, 4'h0, 1, 3'd3, 8'd4);
        // FE 02 01 EF dispatches normally (busy on other handlers ignored)
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'h01, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'hEF, 4'hE, 4'h1, 0, 3'd3, 8'd4);
        // Offending byte 0xFE must not open a frame: following 02 04 EF ignored
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'h04, 4'h0, 4'h0, 0, 3'd3, 8'd4);
        add(1, 8'hFE, 4'h0, 4'h0, 1, 3'd3, 8'd5);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'h04, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'hEF, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        // Back-to-back: FE on the start-pulse cycle opens the next frame
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'h04, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'hEF, 4'h0, 4'h8, 0, 3'd3, 8'd5);
        add(1, 8'hFE, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'h02, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'h04, 4'h0, 4'h0, 0, 3'd3, 8'd5);
        add(1, 8'hEF, 4'h0, 4'h8, 0, 3'd3, 8'd5);
    end

    // ---------------- main sequence ----------------
    initial begin
        int len;
        int cmd;
        int npay;

        // Reset
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].f, tbl[i].b, tbl[i].busy);
            chk("tbl_start", 64'(cmd_start), 64'(tbl[i].start));
            chk("tbl_err",   64'(frame_err), 64'(tbl[i].err));
            chk("tbl_code",  64'(err_code),  64'(tbl[i].code));
            chk("tbl_count", 64'(err_count), 64'(tbl[i].cnt));
        end

        // Payload of a full-length frame, then a shorter one clears the tail
        cyc(1, 8'hFE, 4'h0); cyc(1, 8'h0A, 4'h0); cyc(1, 8'h02, 4'h0);
        for (int i = 0; i < MAX_PAY; i++) cyc(1, 8'(8'hA0 + i), 4'h0);
        cyc(1, 8'hEF, 4'h0);
        chk("full_payload", cmd_payload, 64'hA7A6A5A4A3A2A1A0);
        chk("full_len", 64'(cmd_pay_len), 64'd8);
        cyc(1, 8'hFE, 4'h0); cyc(1, 8'h05, 4'h0); cyc(1, 8'h01, 4'h0);
        cyc(1, 8'h11, 4'h0); cyc(1, 8'h22, 4'h0); cyc(1, 8'h33, 4'h0);
        cyc(1, 8'hEF, 4'h0);
        chk("short_payload", cmd_payload, 64'h0000000000332211);
        chk("short_len", 64'(cmd_pay_len), 64'd3);

        // Timeout: FE 03 02, then TO idle cycles
        cyc(1, 8'hFE, 4'h0); cyc(1, 8'h03, 4'h0); cyc(1, 8'h02, 4'h0);
        for (int k = 1; k < TO; k++) cyc(0, 8'h00, 4'h0);
        chk("tout_pending_busy", 64'(rx_busy), 64'd1);
        chk("tout_pending_err", 64'(frame_err), 64'd0);
        cyc(0, 8'h00, 4'h0);
        chk("tout_err", 64'(frame_err), 64'd1);
        chk("tout_code", 64'(err_code), 64'd5);
        chk("tout_rx_busy", 64'(rx_busy), 64'd0);
        cyc(1, 8'hFE, 4'h0); cyc(1, 8'h02, 4'h0); cyc(1, 8'h02, 4'h0);
        cyc(1, 8'hEF, 4'h0);
        chk("after_tout_start", 64'(cmd_start), 64'h2);

        // A byte on the would-be timeout cycle wins
        cyc(1, 8'hFE, 4'h0);
        for (int k = 1; k < TO; k++) cyc(0, 8'h00, 4'h0);
        cyc(1, 8'h02, 4'h0);
        chk("tie_no_err", 64'(frame_err), 64'd0);
        chk("tie_rx_busy", 64'(rx_busy), 64'd1);
        cyc(1, 8'h03, 4'h0); cyc(1, 8'hEF, 4'h0);
        chk("tie_start", 64'(cmd_start), 64'h4);

        // Asynchronous reset mid-payload
        cyc(1, 8'hFE, 4'h0); cyc(1, 8'h05, 4'h0); cyc(1, 8'h01, 4'h0); cyc(1, 8'h44, 4'h0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        cyc(1, 8'h55, 4'h0); cyc(1, 8'h66, 4'h0); cyc(1, 8'hEF, 4'h0);
        chk("post_rst_start", 64'(cmd_start), 64'h0);
        chk("post_rst_err", 64'(frame_err), 64'd0);

        // Randomized frame stream
        for (int fr = 0; fr < 250; fr++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(2, MAX_PAY + 2);
            cmd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(1, N_CMD);
            npay = (len >= 2 && len <= MAX_PAY + 2) ? len - 2 : $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) rnd_byte(8'($urandom));
            rnd_byte(8'hFE);
            rnd_byte(8'(len));
            rnd_byte(8'(cmd));
            for (int i = 0; i < npay; i++) rnd_byte(8'($urandom));
            if ($urandom_range(0, 29) == 0) repeat (TO + 2) cyc(0, 8'h00, rnd_busy());
            rnd_byte(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hEF);
        end

        // Error counter saturation: 300 bad frames
        for (int i = 0; i < 300; i++) begin
            cyc(1, 8'hFE, 4'h0);
            cyc(1, 8'h00, 4'h0);
        end
        chk("sat_count", 64'(err_count), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
